// File: rtl/control_sequencer_if.sv
// ------------------------------------------------------------------
// control_sequencer_if: datapath <-> control unit strobe bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if;
  logic        Stop;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Run;
  logic        IncPC, PC_enable, PCout, MAR_enable, MDR_enable, MDR_read, MDRout, IR_enable, RAM_write;
  logic        Gra, Grb, Grc, R_in, R_out, BAout, Cout, Cin;
  logic        Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout;
  logic        CON_enable, InPortout, OutPort_enable, Yout;

  modport master (
    input  Stop, IR, CON_FF,
    output Run,
    output IncPC, PC_enable, PCout, MAR_enable, MDR_enable, MDR_read, MDRout, IR_enable, RAM_write,
    output Gra, Grb, Grc, R_in, R_out, BAout, Cout, Cin,
    output Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout,
    output CON_enable, InPortout, OutPort_enable, Yout
  );

  modport slave (
    output Stop, IR, CON_FF,
    input  Run,
    input  IncPC, PC_enable, PCout, MAR_enable, MDR_enable, MDR_read, MDRout, IR_enable, RAM_write,
    input  Gra, Grb, Grc, R_in, R_out, BAout, Cout, Cin,
    input  Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout,
    input  CON_enable, InPortout, OutPort_enable, Yout
  );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ------------------------------------------------------------------
// control_sequencer: hardwired fetch/execute strobe sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module control_sequencer (
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  bus
);

  localparam logic [4:0] OP_LDW  = 5'd0,  OP_LDWI = 5'd1,  OP_STW  = 5'd2,  OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4,  OP_SHR  = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8,  OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18, OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24, OP_HALT = 5'd26;

  // T0..T7 encode the step number in the low bits so execute decode can use state[2:0]
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RST = 4'd8, S_HALT = 4'd9
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] op;
  logic [2:0] step;
  logic [2:0] last_step;
  logic       unused_ir_fields;

  assign op               = bus.IR[31:27];
  assign step             = state[2:0];
  assign unused_ir_fields = ^bus.IR[26:0];

  always_ff @(posedge Clock) begin
    if (!Clear) state <= S_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    case (op)
      OP_LDW, OP_STW:                                 last_step = 3'd7;
      OP_MUL, OP_DIV, OP_BR:                          last_step = 3'd6;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
      OP_LDWI:                                        last_step = 3'd5;
      OP_NEG, OP_NOT, OP_JAL:                         last_step = 3'd4;
      default:                                        last_step = 3'd3;
    endcase
  end

  always_comb begin
    state_nxt          = state;
    bus.Run            = 1'b0;
    bus.IncPC          = 1'b0;
    bus.PC_enable      = 1'b0;
    bus.PCout          = 1'b0;
    bus.MAR_enable     = 1'b0;
    bus.MDR_enable     = 1'b0;
    bus.MDR_read       = 1'b0;
    bus.MDRout         = 1'b0;
    bus.IR_enable      = 1'b0;
    bus.RAM_write      = 1'b0;
    bus.Gra            = 1'b0;
    bus.Grb            = 1'b0;
    bus.Grc            = 1'b0;
    bus.R_in           = 1'b0;
    bus.R_out          = 1'b0;
    bus.BAout          = 1'b0;
    bus.Cout           = 1'b0;
    bus.Cin            = 1'b0;
    bus.Y_enable       = 1'b0;
    bus.ZLowIn         = 1'b0;
    bus.ZHighIn        = 1'b0;
    bus.ZLowout        = 1'b0;
    bus.ZHighout       = 1'b0;
    bus.HI_enable      = 1'b0;
    bus.LO_enable      = 1'b0;
    bus.HIout          = 1'b0;
    bus.LOout          = 1'b0;
    bus.CON_enable     = 1'b0;
    bus.InPortout      = 1'b0;
    bus.OutPort_enable = 1'b0;
    bus.Yout           = 1'b0;

    case (state)
      S_RST:  state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      S_T0: begin
        bus.Run = 1'b1; bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; bus.ZLowIn = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        bus.Run = 1'b1; bus.ZLowout = 1'b1; bus.PC_enable = 1'b1; bus.MDR_read = 1'b1; bus.MDR_enable = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        bus.Run = 1'b1; bus.MDRout = 1'b1; bus.IR_enable = 1'b1;
        state_nxt = S_T3;
      end
      default: begin
        bus.Run = 1'b1;
        // Stop and halt are only honoured on the final execute step
        if (step == last_step) state_nxt = (bus.Stop || op == OP_HALT) ? S_HALT : S_T0;
        else                   state_nxt = state_t'(state + 4'd1);

        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
            if (step == 3'd3) begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
            if (step == 3'd4) begin bus.Grc = 1'b1; bus.R_out = 1'b1; bus.ZLowIn = 1'b1; end
            if (step == 3'd5) begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            if (step == 3'd3) begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
            if (step == 3'd4) begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; end
            if (step == 3'd5) begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          end
          OP_LDWI, OP_LDW, OP_STW: begin
            if (step == 3'd3) begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
            if (step == 3'd4) begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; end
            if (step == 3'd5) begin
              bus.ZLowout = 1'b1;
              if (op == OP_LDWI) begin bus.Gra = 1'b1; bus.R_in = 1'b1; end
              else               bus.MAR_enable = 1'b1;
            end
            if (step == 3'd6) begin
              bus.MDR_enable = 1'b1;
              if (op == OP_LDW) bus.MDR_read = 1'b1;
              else begin bus.Gra = 1'b1; bus.R_out = 1'b1; end
            end
            if (step == 3'd7) begin
              if (op == OP_LDW) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
              else              bus.RAM_write = 1'b1;
            end
          end
          OP_MUL, OP_DIV: begin
            if (step == 3'd3) begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
            if (step == 3'd4) begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.ZLowIn = 1'b1; bus.ZHighIn = 1'b1; end
            if (step == 3'd5) begin bus.ZLowout = 1'b1; bus.LO_enable = 1'b1; end
            if (step == 3'd6) begin bus.ZHighout = 1'b1; bus.HI_enable = 1'b1; end
          end
          OP_NEG, OP_NOT: begin
            if (step == 3'd3) begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.ZLowIn = 1'b1; end
            if (step == 3'd4) begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          end
          OP_BR: begin
            if (step == 3'd3) begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.CON_enable = 1'b1; end
            if (step == 3'd4) begin bus.PCout = 1'b1; bus.Y_enable = 1'b1; end
            if (step == 3'd5) begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; bus.ZHighIn = 1'b1; end
            if (step == 3'd6) begin bus.ZLowout = 1'b1; bus.PC_enable = bus.CON_FF; end
          end
          OP_JR:   begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
          OP_JAL: begin
            if (step == 3'd3) begin bus.PCout = 1'b1; bus.Grc = 1'b1; bus.R_in = 1'b1; end
            if (step == 3'd4) begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
          end
          OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          OP_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          OP_OUT:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.OutPort_enable = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ------------------------------------------------------------------
// tb_control_sequencer: directed scoreboard bench for control_sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  localparam int RUN = 0,  INCPC = 1,  PCEN = 2,   PCOUT = 3,  MAR = 4,    MDREN = 5,  MDRRD = 6,  MDROUT = 7;
  localparam int IREN = 8, RAMWR = 9,  GRA = 10,   GRB = 11,   GRC = 12,   RIN = 13,   ROUT = 14,  BAOUT = 15;
  localparam int COUT = 16, YEN = 18,  ZLIN = 19,  ZHIN = 20,  ZLOUT = 21, ZHOUT = 22, HIEN = 23,  LOEN = 24;
  localparam int HIOUT = 25, LOOUT = 26, CONEN = 27, INOUT = 28, OUTEN = 29;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (clk),
    .Clear (clear),
    .bus   (bus)
  );

  logic [30:0] obs;
  assign obs = {bus.Yout, bus.OutPort_enable, bus.InPortout, bus.CON_enable, bus.LOout, bus.HIout,
                bus.LO_enable, bus.HI_enable, bus.ZHighout, bus.ZLowout, bus.ZHighIn, bus.ZLowIn,
                bus.Y_enable, bus.Cin, bus.Cout, bus.BAout, bus.R_out, bus.R_in, bus.Grc, bus.Grb,
                bus.Gra, bus.RAM_write, bus.IR_enable, bus.MDRout, bus.MDR_read, bus.MDR_enable,
                bus.MAR_enable, bus.PCout, bus.PC_enable, bus.IncPC, bus.Run};

  int          checks = 0;
  int          errors = 0;
  logic [30:0] exp_q[$];

  function automatic int last_of(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2)                  return 7;
    if (op == 5'd14 || op == 5'd15 || op == 5'd18) return 6;
    if (op >= 5'd1 && op <= 5'd13)                 return 5;
    if (op == 5'd16 || op == 5'd17 || op == 5'd20) return 4;
    return 3;
  endfunction

  // Expected strobe word for one cycle of an instruction, straight from the control table
  function automatic logic [30:0] model(input int s, input logic [4:0] op, input logic con);
    logic [30:0] v;
    v = '0;
    v[RUN] = 1'b1;
    if (s == 0) begin v[PCOUT] = 1; v[MAR] = 1; v[INCPC] = 1; v[ZLIN] = 1; end
    else if (s == 1) begin v[ZLOUT] = 1; v[PCEN] = 1; v[MDRRD] = 1; v[MDREN] = 1; end
    else if (s == 2) begin v[MDROUT] = 1; v[IREN] = 1; end
    else if (op >= 5'd3 && op <= 5'd10) begin
      if (s == 3) begin v[GRB] = 1; v[ROUT] = 1; v[YEN] = 1; end
      if (s == 4) begin v[GRC] = 1; v[ROUT] = 1; v[ZLIN] = 1; end
      if (s == 5) begin v[ZLOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    end else if (op >= 5'd11 && op <= 5'd13) begin
      if (s == 3) begin v[GRB] = 1; v[ROUT] = 1; v[YEN] = 1; end
      if (s == 4) begin v[COUT] = 1; v[ZLIN] = 1; end
      if (s == 5) begin v[ZLOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    end else if (op <= 5'd2) begin
      if (s == 3) begin v[GRB] = 1; v[BAOUT] = 1; v[YEN] = 1; end
      if (s == 4) begin v[COUT] = 1; v[ZLIN] = 1; end
      if (s == 5 && op == 5'd1) begin v[ZLOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
      if (s == 5 && op != 5'd1) begin v[ZLOUT] = 1; v[MAR] = 1; end
      if (s == 6 && op == 5'd0) begin v[MDRRD] = 1; v[MDREN] = 1; end
      if (s == 6 && op == 5'd2) begin v[GRA] = 1; v[ROUT] = 1; v[MDREN] = 1; end
      if (s == 7 && op == 5'd0) begin v[MDROUT] = 1; v[GRA] = 1; v[RIN] = 1; end
      if (s == 7 && op == 5'd2) v[RAMWR] = 1;
    end else if (op == 5'd14 || op == 5'd15) begin
      if (s == 3) begin v[GRA] = 1; v[ROUT] = 1; v[YEN] = 1; end
      if (s == 4) begin v[GRB] = 1; v[ROUT] = 1; v[ZLIN] = 1; v[ZHIN] = 1; end
      if (s == 5) begin v[ZLOUT] = 1; v[LOEN] = 1; end
      if (s == 6) begin v[ZHOUT] = 1; v[HIEN] = 1; end
    end else if (op == 5'd16 || op == 5'd17) begin
      if (s == 3) begin v[GRB] = 1; v[ROUT] = 1; v[ZLIN] = 1; end
      if (s == 4) begin v[ZLOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    end else if (op == 5'd18) begin
      if (s == 3) begin v[GRA] = 1; v[ROUT] = 1; v[CONEN] = 1; end
      if (s == 4) begin v[PCOUT] = 1; v[YEN] = 1; end
      if (s == 5) begin v[COUT] = 1; v[ZLIN] = 1; v[ZHIN] = 1; end
      if (s == 6) begin v[ZLOUT] = 1; v[PCEN] = con; end
    end else if (op == 5'd19) begin v[GRA] = 1; v[ROUT] = 1; v[PCEN] = 1; end
    else if (op == 5'd20) begin
      if (s == 3) begin v[PCOUT] = 1; v[GRC] = 1; v[RIN] = 1; end
      if (s == 4) begin v[GRA] = 1; v[ROUT] = 1; v[PCEN] = 1; end
    end
    else if (op == 5'd21) begin v[INOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    else if (op == 5'd22) begin v[GRA] = 1; v[ROUT] = 1; v[OUTEN] = 1; end
    else if (op == 5'd23) begin v[HIOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    else if (op == 5'd24) begin v[LOOUT] = 1; v[GRA] = 1; v[RIN] = 1; end
    return v;
  endfunction

  task automatic check_next(input string tag);
    logic [30:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_next($sformatf("%s idle%0d", name, i));
    end
  endtask

  // Runs one instruction from T0; IR is garbage during fetch and valid from T3
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                           input logic stop_last, input logic stop_glitch, input int upto);
    logic [4:0] op;
    int         n;
    op = ir[31:27];
    n  = (last_of(op) < upto) ? last_of(op) : upto;
    bus.CON_FF = con;
    for (int s = 0; s <= n; s++) exp_q.push_back(model(s, op, con));
    for (int s = 0; s <= n; s++) begin
      @(negedge clk);
      check_next($sformatf("%s T%0d", name, s));
      if (s == 0) bus.IR = $urandom;
      if (s == 2) bus.IR = ir;
      if (stop_glitch && s == 1) bus.Stop = 1'b1;
      if (stop_glitch && s == 2) bus.Stop = 1'b0;
      if (s == n) bus.Stop = stop_last;
    end
  endtask

  initial begin
    bus.Stop   = 1'b0;
    bus.IR     = 32'h0;
    bus.CON_FF = 1'b0;
    clear      = 1'b0;

    idle_cycles("reset", 2);
    clear = 1'b1;
    run_instr("ldw_abort", 32'h00800055, 1'b0, 1'b0, 1'b0, 4);
    clear = 1'b0;
    idle_cycles("reset_mid_ldw", 2);
    clear = 1'b1;

    run_instr("add",      32'h18918000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("brzr_t",   32'h91000023, 1'b1, 1'b0, 1'b0, 99);
    run_instr("brzr_f",   32'h91000023, 1'b0, 1'b0, 1'b0, 99);
    run_instr("ldw",      32'h00800055, 1'b0, 1'b0, 1'b0, 99);
    run_instr("stw",      32'h10800055, 1'b0, 1'b0, 1'b0, 99);
    run_instr("mul",      32'h71880000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("addi",     32'h5888000A, 1'b0, 1'b0, 1'b0, 99);
    run_instr("neg",      32'h80880000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("jal",      32'hA7800000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("jr",       32'h98800000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("mfhi",     32'hB8800000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("mflo",     32'hC0800000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("in",       32'hA8800000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("div_glit", 32'h79880000, 1'b0, 1'b0, 1'b1, 99);
    run_instr("nop",      32'hC8000000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("undef",    32'hF8000000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("ldwi",     32'h08800055, 1'b0, 1'b0, 1'b0, 99);

    run_instr("out_stop", 32'hB0800000, 1'b0, 1'b1, 1'b0, 99);
    idle_cycles("stop_halt_a", 1);
    bus.Stop = 1'b0;
    idle_cycles("stop_halt_b", 3);
    clear = 1'b0;
    idle_cycles("clear_pulse1", 1);
    clear = 1'b1;

    run_instr("halt",     32'hD0000000, 1'b0, 1'b0, 1'b0, 99);
    idle_cycles("halted", 10);
    clear = 1'b0;
    idle_cycles("clear_pulse2", 1);
    clear = 1'b1;
    run_instr("add_again", 32'h18918000, 1'b0, 1'b0, 1'b0, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit single-bus CPU. Each cycle it drives the datapath control strobes that the bring-up benches currently hand-sequence. It steps through a 3-cycle fetch, then an opcode-specific execute sequence decoded from IR[31:27]. For branches it samples the datapath's CON flip-flop, and it halts on `halt` or on an external Stop request.

## Interface
Parameters:
- none

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Clear  in  1  reset, synchronous, active-low (0 = reset)
- Stop  in  1  level request to halt after the current instruction
- IR  in  32  datapath IR register output; opcode is IR[31:27]
- CON_FF  in  1  branch-condition flip-flop output from the datapath
- Run  out  1  1 while sequencing, 0 in reset or HALT
- IncPC, PC_enable, PCout, MAR_enable, MDR_enable, MDR_read, MDRout, IR_enable, RAM_write  out  1 each  memory/PC strobes
- Gra, Grb, Grc, R_in, R_out, BAout, Cout, Cin  out  1 each  register-select and constant strobes; Cin is always 0
- Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout  out  1 each  ALU-side strobes
- CON_enable, InPortout, OutPort_enable, Yout  out  1 each  I/O and condition strobes; Yout is always 0

## Operation
- States: T0..T7 (step counter) plus HALT. Every strobe is a Moore decode of state and opcode, except the branch T6 PC_enable, which is gated by CON_FF.
- Strobes not listed for a cycle are 0.
- Fetch, common to all instructions:
  - T0: PCout, MAR_enable, IncPC, ZLowIn
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable
  - T2: MDRout, IR_enable
- IR is valid from T3 onward. Execute sequences, per opcode:
  - add/sub/shr/shl/ror/rol/and/or: T3 Grb R_out Y_enable; T4 Grc R_out ZLowIn; T5 ZLowout Gra R_in
  - mul/div: T3 Gra R_out Y_enable; T4 Grb R_out ZLowIn ZHighIn; T5 ZLowout LO_enable; T6 ZHighout HI_enable
  - neg/not: T3 Grb R_out ZLowIn; T4 ZLowout Gra R_in
  - addi/andi/ori: T3 Grb R_out Y_enable; T4 Cout ZLowIn; T5 ZLowout Gra R_in
  - ldwi: T3 Grb BAout Y_enable; T4 Cout ZLowIn; T5 ZLowout Gra R_in
  - ldw: ldwi T3–T4, then T5 ZLowout MAR_enable; T6 MDR_read MDR_enable; T7 MDRout Gra R_in
  - stw: ldwi T3–T4, then T5 ZLowout MAR_enable; T6 Gra R_out MDR_enable (MDR_read=0); T7 RAM_write
  - branch (10010): T3 Gra R_out CON_enable; T4 PCout Y_enable; T5 Cout ZLowIn ZHighIn; T6 ZLowout, PC_enable=CON_FF
  - jr: T3 Gra R_out PC_enable
  - jal: T3 PCout Grc R_in (assembler encodes Rc=15); T4 Gra R_out PC_enable
  - mfhi: T3 HIout Gra R_in
  - mflo: T3 LOout Gra R_in
  - in: T3 InPortout Gra R_in
  - out: T3 Gra R_out OutPort_enable
  - nop and undefined opcodes: T3 all strobes 0
  - halt: T3 all strobes 0, then enter HALT
- After the last execute cycle the next state is T0. If Stop=1 during that last cycle, the next state is HALT instead.
- HALT: all strobes 0 and Run=0. The only exit is Clear=0.

## Timing
- Clear=0 sampled at an edge: state becomes T0-pending and every output, including Run, reads 0 in the following cycle. This holds at any point mid-instruction; no strobe from the aborted sequence appears after that edge.
- First edge with Clear=1: state T0 and Run=1. T0 strobes are visible in the cycle after that edge.
- Instruction lengths, fetch included:
  - 4 cycles: jr, mfhi, mflo, in, out, nop
  - 5 cycles: neg, not, jal
  - 6 cycles: ALU-reg, immediate, ldwi
  - 7 cycles: mul, div, branch
  - 8 cycles: ldw, stw
- CON_FF is sampled combinationally during branch T6 only; the datapath latches CON at the end of T3.
- Stop and halt take priority over the next fetch. A Stop raised and dropped within T0..T(last−1) is ignored.
- Fetch never depends on IR, so a stale IR during T0–T2 has no effect.

## Test plan
- Reset: hold Clear=0 for 2 cycles mid-ldw → all outputs 0, Run=0. Release → next cycle PCout=MAR_enable=IncPC=ZLowIn=1.
- add r1,r2,r3, IR=0x18918000 → T3 Grb/R_out/Y_enable, T4 Grc/R_out/ZLowIn, T5 ZLowout/Gra/R_in. T0 strobes return on cycle 7.
- brzr r2,35, IR=0x91000023: with CON_FF=1 → T6 PC_enable=1. With CON_FF=0 → T6 PC_enable=0, ZLowout=1. Both return to T0 after 7 cycles.
- ldw r1,0x55(r0), IR=0x00800055 → T3 BAout, T6 MDR_read=MDR_enable=1, T7 MDRout/Gra/R_in. stw with the same fields → T7 RAM_write=1 only.
- mul r3,r1, IR=0x71880000 → T4 ZLowIn=ZHighIn=1, T5 LO_enable, T6 HI_enable. Total 7 cycles.
- halt, IR=0xD0000000 → Run=0 from cycle after T3, outputs held 0 for 10+ cycles. Separately, Stop=1 during an `out` T3 → HALT after T3. A 1-cycle Clear=0 pulse → restart at T0.
